// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..MAX_DATA_BITS data, none/even/odd parity, 1 or 2 stop bits.
// Frame settings are latched on the valid/ready accept edge; bit timing advances only on baud_tick.
module uart_tx_cfg #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     baud_tick,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  input  logic [3:0]               data_bits,
  input  logic [1:0]               parity_mode,
  input  logic                     two_stop,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     frame_done
);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(MAX_DATA_BITS);
  localparam int NBW = $clog2(MAX_DATA_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                   state_q;
  logic [SCW-1:0]           sample_cnt_q;
  logic [BIW-1:0]           bit_idx_q;
  logic                     stop_cnt_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic [NBW-1:0]           nbits_q;
  logic [1:0]               pmode_q;
  logic                     two_stop_q;
  logic                     tx_out_q;
  logic                     tx_busy_q;
  logic                     frame_done_q;

  logic [NBW-1:0] nbits_d;
  logic [BIW-1:0] bit_nxt;
  logic           par_bit;
  logic           par_en;
  logic           bit_end;
  logic           last_bit;

  always_comb begin
    nbits_d = NBW'(MAX_DATA_BITS);
    if (32'(data_bits) < 32'd5) begin
      nbits_d = NBW'(5);
    end else if (32'(data_bits) <= 32'(MAX_DATA_BITS)) begin
      nbits_d = NBW'(data_bits);
    end
  end

  // Odd parity starts from 1, even from 0; only the effective bits contribute.
  always_comb begin
    par_bit = pmode_q[1];
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < int'(nbits_q)) begin
        par_bit = par_bit ^ data_q[i];
      end
    end
  end

  assign par_en   = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign bit_end  = baud_tick && (sample_cnt_q == SCW'(OVERSAMPLE - 1));
  assign bit_nxt  = bit_idx_q + 1'b1;
  assign last_bit = (32'(bit_idx_q) + 32'd1) == 32'(nbits_q);

  always_ff @(posedge clk) begin
    frame_done_q <= 1'b0;
    if (reset) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      data_q       <= '0;
      nbits_q      <= '0;
      pmode_q      <= 2'b00;
      two_stop_q   <= 1'b0;
      tx_out_q     <= 1'b1;
      tx_busy_q    <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (tx_valid) begin
        data_q       <= tx_data;
        nbits_q      <= nbits_d;
        pmode_q      <= parity_mode;
        two_stop_q   <= two_stop;
        sample_cnt_q <= '0;
        bit_idx_q    <= '0;
        stop_cnt_q   <= 1'b0;
        state_q      <= S_START;
        tx_out_q     <= 1'b0;
        tx_busy_q    <= 1'b1;
      end
    end else if (baud_tick) begin
      if (!bit_end) begin
        sample_cnt_q <= sample_cnt_q + 1'b1;
      end else begin
        sample_cnt_q <= '0;
        case (state_q)
          S_START: begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            tx_out_q  <= data_q[0];
          end
          S_DATA: begin
            if (!last_bit) begin
              bit_idx_q <= bit_nxt;
              tx_out_q  <= data_q[bit_nxt];
            end else if (par_en) begin
              state_q  <= S_PARITY;
              tx_out_q <= par_bit;
            end else begin
              state_q    <= S_STOP;
              stop_cnt_q <= 1'b0;
              tx_out_q   <= 1'b1;
            end
          end
          S_PARITY: begin
            state_q    <= S_STOP;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= 1'b1;
          end
          S_STOP: begin
            if (stop_cnt_q == two_stop_q) begin
              state_q      <= S_IDLE;
              tx_busy_q    <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_ready   = (state_q == S_IDLE) && !reset;
  assign tx_out     = tx_out_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: expected line levels come from a per-frame bit list indexed by elapsed baud ticks.
module tb_uart_tx_cfg;
  localparam int OS   = 16;
  localparam int MAXB = 9;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            baud_tick = 1'b0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [MAXB-1:0] tx_data = '0;
  logic [3:0]      data_bits = 4'd8;
  logic [1:0]      parity_mode = 2'b00;
  logic            two_stop = 1'b0;
  logic            tx_out;
  logic            tx_busy;
  logic            frame_done;

  int checks = 0;
  int errors = 0;
  int tick_period = 1;
  int tick_div = 0;

  uart_tx_cfg #(.MAX_DATA_BITS(MAXB), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx_out      (tx_out),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_div >= tick_period - 1) begin
      tick_div  = 0;
      baud_tick = 1'b1;
    end else begin
      tick_div  = tick_div + 1;
      baud_tick = 1'b0;
    end
  end

  // Sends one frame and checks every clk of it against the expected bit list.
  task automatic run_frame(input string name, input logic [MAXB-1:0] d, input logic [3:0] nb,
                           input logic [1:0] pm, input logic ts, input bit preset, input bit hold,
                           input logic [MAXB-1:0] d2, input logic [3:0] nb2, input logic [1:0] pm2,
                           input logic ts2, output int waited);
    bit lv[$];
    bit par, tk, done;
    int n, total, t, cyc, bad, first_bad, rbad, lo, hi;
    n = (nb < 5) ? 5 : ((nb > MAXB) ? MAXB : int'(nb));
    par = 1'b0;
    lv.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      lv.push_back(d[i]);
      par = par ^ d[i];
    end
    if (pm == 2'b01) lv.push_back(par);
    else if (pm == 2'b10) lv.push_back(~par);
    lv.push_back(1'b1);
    if (ts) lv.push_back(1'b1);
    total = lv.size() * OS;

    @(negedge clk);
    if (!preset) begin
      tx_data = d; data_bits = nb; parity_mode = pm; two_stop = ts; tx_valid = 1'b1;
    end
    waited = 0;
    while (!tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: tx_ready=%b, required 1", name, tx_ready);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    checks++;
    if (tx_out !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s start: out/busy/ready=%b%b%b, required 010", name, tx_out, tx_busy, tx_ready);
    end
    @(negedge clk);
    if (hold) begin
      tx_data = d2; data_bits = nb2; parity_mode = pm2; two_stop = ts2;
    end else begin
      tx_valid = 1'b0;
      tx_data = MAXB'($urandom); data_bits = 4'($urandom);
      parity_mode = 2'($urandom); two_stop = 1'($urandom);
    end

    t = 0; cyc = 0; bad = 0; first_bad = -1; rbad = 0; done = 1'b0;
    while (!done && cyc < total * tick_period + 64) begin
      @(posedge clk);
      tk = baud_tick;
      #1;
      cyc++;
      if (tk) t++;
      if (t >= total) begin
        done = 1'b1;
      end else begin
        if (tx_out !== lv[t / OS] || tx_busy !== 1'b1 || frame_done !== 1'b0) begin
          if (first_bad < 0) first_bad = cyc;
          bad++;
        end
        if (tx_ready !== 1'b0) rbad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s line: %0d bad cycles (first at %0d), required 0", name, bad, first_bad);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL %s ready_low: tx_ready high in %0d frame cycles, required 0", name, rbad);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: frame did not end within %0d cycles", name, cyc);
    end else if (frame_done !== 1'b1 || tx_busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL %s done: done/busy/out=%b%b%b, required 101", name, frame_done, tx_busy, tx_out);
    end
    lo = (total - 1) * tick_period + 1;
    hi = total * tick_period;
    checks++;
    if (cyc < lo || cyc > hi) begin
      errors++;
      $display("FAIL %s length: %0d clks, required %0d..%0d", name, cyc, lo, hi);
    end
    if (!hold) begin
      @(posedge clk); #1;
      checks++;
      if (frame_done !== 1'b0 || tx_out !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse: done/out/busy=%b%b%b after frame, required 010", name, frame_done, tx_out, tx_busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b1; tx_data = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out/busy/done/ready=%b%b%b%b, required 1000", tx_out, tx_busy, frame_done, tx_ready);
    end
    @(negedge clk);
    reset = 1'b0; tx_valid = 1'b0;
    #1;
    checks++;
    if (tx_ready !== 1'b1 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ready/out=%b%b, required 11", tx_ready, tx_out);
    end
  endtask

  task automatic test_8n1();
    int w;
    tick_period = 1;
    run_frame("8n1_55", 9'h055, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
  endtask

  task automatic test_parity();
    int w;
    run_frame("7e1_41", 9'h041, 4'd7, 2'b01, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    run_frame("7o1_41", 9'h041, 4'd7, 2'b10, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    run_frame("8o2_ff", 9'h0FF, 4'd8, 2'b10, 1'b1, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    run_frame("8x1_mode3", 9'h0C3, 4'd8, 2'b11, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    run_frame("b2b_a5", 9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 9'h03C, 4'd8, 2'b00, 1'b0, w);
    run_frame("b2b_3c", 9'h03C, 4'd8, 2'b00, 1'b0, 1'b1, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL b2b_gap: waited %0d extra idle cycles, required 0", w);
    end
  endtask

  task automatic test_slow_tick();
    int w;
    tick_period = 4;
    run_frame("slow_8n1", 9'h096, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    run_frame("slow_bits3", 9'h1F8, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    run_frame("slow_bits12", 9'h1C3, 4'd12, 2'b00, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    tick_period = 1;
  endtask

  task automatic test_reset_mid();
    int t, cyc, w;
    bit tk, seen;
    @(negedge clk);
    tx_data = '0; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0; tx_valid = 1'b1;
    cyc = 0;
    while (!tx_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0; cyc = 0; seen = 1'b0;
    while (t < 4 * OS + 3 && cyc < 2000) begin
      @(posedge clk);
      tk = baud_tick;
      #1;
      cyc++;
      if (tk) t++;
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (tx_out !== 1'b0 || tx_busy !== 1'b1 || seen) begin
      errors++;
      $display("FAIL rst_pre: out/busy/done_seen=%b%b%b in data bit 3, required 010", tx_out, tx_busy, seen);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: out/busy/done/ready=%b%b%b%b, required 1000", tx_out, tx_busy, frame_done, tx_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: tx_ready=%b, required 1", tx_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (frame_done !== 1'b0 || tx_out !== 1'b1 || tx_busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_quiet: line not idle after abandoned frame, got activity, required none");
    end
    run_frame("rst_12", 9'h012, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    string nm;
    for (int k = 0; k < 8; k++) begin
      tick_period = $urandom_range(1, 3);
      nm = $sformatf("rand%0d", k);
      run_frame(nm, MAXB'($urandom), 4'($urandom_range(0, 15)), 2'($urandom), 1'($urandom),
                1'b0, 1'b0, '0, 4'd0, 2'b00, 1'b0, w);
    end
    tick_period = 1;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_slow_tick();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
